// File: rtl/bcd_scan_pkg.sv
// Shared constants and helpers for the multi-digit BCD scan counter:
// FSM state encodings, active-low 7-segment patterns and digit helpers.
package bcd_scan_pkg;

  // Run/stop FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Largest legal BCD digit value
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Saturate out-of-range switch values to 9 so the count always holds BCD
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Decode one BCD digit to its active-low segment pattern; non-BCD blanks
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: parallel load, up/down count on enable, and a
// carry/borrow output that enables the next decade in the ripple chain.
module bcd_digit
  import bcd_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ud,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       co
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: load beats counting; counting wraps 9->0 up, 0->9 down
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = ld_val;
    end else if (en) begin
      if (ud) begin
        q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  // Carry (up) or borrow (down) fires only when this decade is about to wrap
  always_comb begin
    co = en & (ud ? (q_q == BCD_MAX) : (q_q == 4'd0));
  end

  // Digit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit up/down BCD counter with run/stop control, digit-serial load,
// a rollover pulse, and a multiplexed common-anode 7-segment scanner.
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int CLK_HZ   = 50000000,
  parameter int COUNT_HZ = 1,
  parameter int SCAN_HZ  = 1000
) (
  input  logic                clk_50M,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                load,
  input  logic                ud,
  input  logic [3:0]          digit,
  output logic [4*NDIG-1:0]   count_bcd,
  output logic [NDIG-1:0]     anode,
  output logic [6:0]          seg,
  output logic                rollover,
  output logic                running
);

  localparam int TICK_DIV = CLK_HZ / COUNT_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [0:0]      state_q,    state_d;
  logic            running_q,  running_d;
  logic            load_q,     load_d;
  logic            rollover_q, rollover_d;
  logic [TW-1:0]   presc_q,    presc_d;
  logic [SW-1:0]   sdiv_q,     sdiv_d;
  logic [IW-1:0]   idx_q,      idx_d;
  logic [NDIG-1:0] anode_q,    anode_d;
  logic [6:0]      seg_q,      seg_d;

  logic            tick;
  logic            load_edge;
  logic [3:0]      cur_digit;
  logic [NDIG-1:0] dig_en;
  logic [NDIG-1:0] dig_co;
  logic [3:0]      dig_q  [NDIG];
  logic [3:0]      dig_ld [NDIG];

  // Run/stop FSM: stop always wins, start only leaves IDLE
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start && (state_q == IDLE)) begin
      state_d = RUN;
    end
    running_d = (state_d == RUN);
  end

  // Count-rate prescaler: free-runs in RUN, parked at zero otherwise
  always_comb begin
    tick    = (state_q == RUN) && (presc_q == TW'(TICK_DIV - 1));
    presc_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      presc_d = tick ? '0 : presc_q + TW'(1);
    end
  end

  // Load edge detect; a load edge suppresses a coincident tick
  always_comb begin
    load_d     = load;
    load_edge  = load & ~load_q;
    rollover_d = dig_co[NDIG-1];
  end

  // Decade chain: the shift load feeds each digit from its lower neighbour,
  // and the count enable ripples upward through carry/borrow outputs
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign dig_en[i] = tick & ~load_edge;
      assign dig_ld[i] = clamp_bcd(digit);
    end else begin : g_upper
      assign dig_en[i] = dig_co[i-1];
      assign dig_ld[i] = dig_q[i-1];
    end

    bcd_digit u_digit (
      .clk    (clk_50M),
      .rst    (reset),
      .en     (dig_en[i]),
      .ud     (ud),
      .load   (load_edge),
      .ld_val (dig_ld[i]),
      .q      (dig_q[i]),
      .co     (dig_co[i])
    );

    assign count_bcd[4*i +: 4] = dig_q[i];
  end

  // Scan divider and digit index; index wraps NDIG-1 back to 0
  always_comb begin
    sdiv_d = sdiv_q + SW'(1);
    idx_d  = idx_q;
    if (sdiv_q == SW'(SCAN_DIV - 1)) begin
      sdiv_d = '0;
      idx_d  = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Select the digit under the current index and build the display outputs
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx_q) begin
        cur_digit = dig_q[i];
      end
    end
    anode_d = ~(NDIG'(1) << idx_q);
    seg_d   = seg_decode(cur_digit);
  end

  // All control, prescaler and display registers
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      load_q     <= 1'b0;
      rollover_q <= 1'b0;
      presc_q    <= '0;
      sdiv_q     <= '0;
      idx_q      <= '0;
      anode_q    <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      load_q     <= load_d;
      rollover_q <= rollover_d;
      presc_q    <= presc_d;
      sdiv_q     <= sdiv_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign anode    = anode_q;
  assign seg      = seg_q;
  assign rollover = rollover_q;
  assign running  = running_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with NDIG=4, TICK_DIV=10, SCAN_DIV=2.
module tb_bcd_scan_counter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        load;
  logic        ud;
  logic [3:0]  digit;
  logic [15:0] count_bcd;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        rollover;
  logic        running;

  int          testCount;
  int          failCount;
  int unsigned edgeCount;
  int unsigned expIdx;
  logic [3:0]  expAnode;
  logic [6:0]  expSeg;
  logic [15:0] shownValue;
  logic [6:0]  segTable [10];

  bcd_scan_counter #(
    .NDIG     (4),
    .CLK_HZ   (100),
    .COUNT_HZ (10),
    .SCAN_HZ  (50)
  ) dut (
    .clk_50M   (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .ud        (ud),
    .digit     (digit),
    .count_bcd (count_bcd),
    .anode     (anode),
    .seg       (seg),
    .rollover  (rollover),
    .running   (running)
  );

  // 20 ns clock
  always #10 clk = ~clk;

  // Edges since the last reset release, used to predict the scan position
  always @(posedge clk or posedge reset) begin
    if (reset) edgeCount <= 0;
    else       edgeCount <= edgeCount + 1;
  end

  // Advance n clocks, landing on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive all control inputs at once
  task automatic applyStimulus(input logic st, input logic sp, input logic ld,
                               input logic u, input logic [3:0] dg);
    start = st;
    stop  = sp;
    load  = ld;
    ud    = u;
    digit = dg;
  endtask

  // One clean load pulse: high for one clock, low for one clock
  task automatic loadDigit(input logic [3:0] dg);
    digit = dg;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
    step(1);
  endtask

  // Compare observed against expected and count the outcome
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Directed sequence covering reset, counting, wrap, control and scan
  initial begin
    segTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    testCount = 0;
    failCount = 0;
    clk = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

    // Reset state
    step(5);
    checkOutput("rst_count", count_bcd, 16'h0000);
    checkOutput("rst_anode", anode, 4'hF);
    checkOutput("rst_seg", seg, 7'h7F);
    checkOutput("rst_running", running, 1'b0);
    checkOutput("rst_rollover", rollover, 1'b0);
    reset = 1'b0;
    step(1);
    checkOutput("first_anode", anode, 4'b1110);
    checkOutput("first_seg", seg, 7'h40);

    // Test 1: count up from zero
    $display("[TB] test 1: basic up count");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1);
    checkOutput("t1_running", running, 1'b1);
    for (int k = 1; k <= 100; k++) begin
      step(1);
      checkOutput("t1_no_rollover", rollover, 1'b0);
      if (k == 9)   checkOutput("t1_count_e9", count_bcd, 16'h0000);
      if (k == 10)  checkOutput("t1_count_e10", count_bcd, 16'h0001);
      if (k == 99)  checkOutput("t1_count_e99", count_bcd, 16'h0009);
      if (k == 100) checkOutput("t1_count_e100", count_bcd, 16'h0010);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    step(1);
    checkOutput("t1_stopped", running, 1'b0);
    stop = 1'b0;

    // Test 2: load 9999 then wrap up to 0000
    $display("[TB] test 2: up rollover");
    loadDigit(4'd9); loadDigit(4'd9); loadDigit(4'd9); loadDigit(4'd9);
    checkOutput("t2_loaded", count_bcd, 16'h9999);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1);
    step(9);
    checkOutput("t2_pre_tick", count_bcd, 16'h9999);
    checkOutput("t2_pre_roll", rollover, 1'b0);
    step(1);
    checkOutput("t2_wrapped", count_bcd, 16'h0000);
    checkOutput("t2_roll_high", rollover, 1'b1);
    step(1);
    checkOutput("t2_roll_low", rollover, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    step(1);
    stop = 1'b0;

    // Test 3: down wrap from 0000 and plain borrow from 0100
    $display("[TB] test 3: down count");
    ud = 1'b0;
    loadDigit(4'd0); loadDigit(4'd0); loadDigit(4'd0); loadDigit(4'd0);
    checkOutput("t3_zero", count_bcd, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(10);
    checkOutput("t3_pre_tick", count_bcd, 16'h0000);
    step(1);
    checkOutput("t3_wrapped", count_bcd, 16'h9999);
    checkOutput("t3_roll_high", rollover, 1'b1);
    step(1);
    checkOutput("t3_roll_low", rollover, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1);
    stop = 1'b0;
    loadDigit(4'd0); loadDigit(4'd1); loadDigit(4'd0); loadDigit(4'd0);
    checkOutput("t3_loaded_0100", count_bcd, 16'h0100);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    step(11);
    checkOutput("t3_borrow", count_bcd, 16'h0099);
    checkOutput("t3_borrow_noroll", rollover, 1'b0);
    step(1);
    checkOutput("t3_borrow_noroll2", rollover, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(1);
    stop = 1'b0;

    // Test 4: stop priority, freeze and restart timing
    $display("[TB] test 4: start/stop control");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
    step(2);
    checkOutput("t4_both_idle", running, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(1);
    checkOutput("t4_run", running, 1'b1);
    step(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    step(1);
    checkOutput("t4_stop", running, 1'b0);
    step(20);
    checkOutput("t4_frozen", count_bcd, 16'h0099);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(10);
    checkOutput("t4_restart_e9", count_bcd, 16'h0099);
    step(1);
    checkOutput("t4_restart_e10", count_bcd, 16'h0100);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    step(1);
    stop = 1'b0;

    // Test 5: held load shifts once with clamp; load beats a coincident tick
    $display("[TB] test 5: load edge and clamp");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hC);
    step(50);
    checkOutput("t5_one_shift", count_bcd, 16'h1009);
    load = 1'b0;
    step(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(10);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    step(1);
    checkOutput("t5_load_wins", count_bcd, 16'h0095);
    checkOutput("t5_load_noroll", rollover, 1'b0);
    load = 1'b0;
    step(9);
    checkOutput("t5_next_pre", count_bcd, 16'h0095);
    step(1);
    checkOutput("t5_next_tick", count_bcd, 16'h0096);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    step(1);
    stop = 1'b0;

    // Test 6: display scan of 1234 and asynchronous reset mid-scan
    $display("[TB] test 6: display scan");
    loadDigit(4'd1); loadDigit(4'd2); loadDigit(4'd3); loadDigit(4'd4);
    checkOutput("t6_loaded", count_bcd, 16'h1234);
    shownValue = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      step(1);
      expIdx   = ((edgeCount - 1) / 2) % 4;
      expAnode = ~(4'b0001 << expIdx);
      expSeg   = segTable[shownValue[expIdx*4 +: 4]];
      checkOutput("t6_anode", anode, expAnode);
      checkOutput("t6_seg", seg, expSeg);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step(3);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_anode", anode, 4'hF);
    checkOutput("t6_rst_seg", seg, 7'h7F);
    checkOutput("t6_rst_count", count_bcd, 16'h0000);
    checkOutput("t6_rst_running", running, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step(2);
    reset = 1'b0;
    step(1);
    checkOutput("t6_rel_anode", anode, 4'b1110);
    checkOutput("t6_rel_seg", seg, 7'h40);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
